// File: rtl/vreg_pkg.sv
// vreg_pkg: shared sizes, FSM state encoding and transfer direction for the
// vector register file serial port.
package vreg_pkg;
  localparam int VREG_ELEMS = 16;
  localparam int VREG_EW = 16;
  localparam int VREG_AW = 3;
  localparam logic DIR_STORE = 1'b0;
  localparam logic DIR_LOAD = 1'b1;
  typedef enum logic [2:0] {IDLE, SETUP, XFER, DRAIN, DONE} state_t;
endpackage

// File: rtl/vec_elem_buf.sv
// vec_elem_buf: ELEMS x EW element buffer with parallel load, indexed read/write
// and a write-through parallel view (contents as they will be after this edge).
module vec_elem_buf
  import vreg_pkg::*;
#(
  parameter int ELEMS = VREG_ELEMS,
  parameter int EW = VREG_EW,
  localparam int IW = $clog2(ELEMS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld,
  input  logic [ELEMS*EW-1:0] ld_vec,
  output logic [ELEMS*EW-1:0] view,
  input  logic [IW-1:0]       rd_idx,
  output logic [EW-1:0]       rd_elem,
  input  logic                wr,
  input  logic [IW-1:0]       wr_idx,
  input  logic [EW-1:0]       wr_elem
);
  logic [ELEMS*EW-1:0] mem;
  always_comb begin
    view = ld ? ld_vec : mem;
    if (wr) view[wr_idx*EW +: EW] = wr_elem;
  end
  assign rd_elem = mem[rd_idx*EW +: EW];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem <= '0;
    else mem <= view;
endmodule

// File: rtl/vreg_serial_master.sv
// vreg_serial_master: turns one-shot vector store/load requests into a burst of
// serial element writes/reads on the register file's element port.
module vreg_serial_master
  import vreg_pkg::*;
#(
  parameter int ELEMS = VREG_ELEMS,
  parameter int EW = VREG_EW,
  parameter int RD_LAT = 1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Start,
  input  logic                Dir,
  input  logic [VREG_AW-1:0]  VAddr,
  input  logic [ELEMS*EW-1:0] VecIn,
  output logic                Busy,
  output logic                Done,
  output logic [ELEMS*EW-1:0] VecOut,
  output logic [VREG_AW-1:0]  Addr,
  output logic                WR_s,
  output logic                RD_s,
  output logic [EW-1:0]       DataOut_s,
  input  logic [EW-1:0]       DataIn_s
);
  localparam int CW = $clog2(ELEMS);
  state_t state, state_nxt;
  logic dir, accept;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RD_LAT-1:0] pv;
  logic [CW-1:0] pidx [RD_LAT];
  logic [ELEMS*EW-1:0] view;
  logic [EW-1:0] elem;
  assign accept = state == IDLE && Start;
  always_comb begin
    state_nxt = state;
    cnt_nxt = '0;
    unique case (state)
      IDLE: state_nxt = Start ? SETUP : IDLE;
      SETUP: state_nxt = XFER;
      XFER: begin
        cnt_nxt = cnt == CW'(ELEMS - 1) ? '0 : cnt + 1'b1;
        if (cnt == CW'(ELEMS - 1)) state_nxt = dir == DIR_LOAD ? DRAIN : DONE;
      end
      DRAIN: begin
        cnt_nxt = cnt == CW'(RD_LAT - 1) ? '0 : cnt + 1'b1;
        if (cnt == CW'(RD_LAT - 1)) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state <= IDLE;
      cnt <= '0;
      dir <= DIR_STORE;
      Addr <= '0;
      VecOut <= '0;
      pv <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      pv <= RD_LAT'({pv, RD_s});
      if (accept) begin
        dir <= Dir;
        Addr <= VAddr;
      end
      // the final capture lands on this same edge, so take the write-through view
      if (state == DRAIN && state_nxt == DONE) VecOut <= view;
    end
  always_ff @(posedge Clk) begin
    pidx[0] <= cnt;
    for (int i = 1; i < RD_LAT; i++) pidx[i] <= pidx[i-1];
  end
  vec_elem_buf #(.ELEMS(ELEMS), .EW(EW)) u_buf (
    .clk(Clk),
    .rst_n(Rst_n),
    .ld(accept && Dir == DIR_STORE),
    .ld_vec(VecIn),
    .view(view),
    .rd_idx(cnt),
    .rd_elem(elem),
    .wr(pv[RD_LAT-1]),
    .wr_idx(pidx[RD_LAT-1]),
    .wr_elem(DataIn_s)
  );
  assign Busy = state != IDLE;
  assign Done = state == DONE;
  assign WR_s = state == XFER && dir == DIR_STORE;
  assign RD_s = state == XFER && dir == DIR_LOAD;
  assign DataOut_s = WR_s ? elem : '0;
endmodule

// File: tb/tb_vreg_serial_master.sv
// tb_vreg_serial_master: drives an RD_LAT=1 and an RD_LAT=3 instance with the same
// requests, each against its own regfile model, and checks every cycle.
module tb_vreg_serial_master;
  logic clk, rst_n, start, dir;
  logic [2:0] vaddr;
  logic [255:0] vecin;
  logic busy[2], done_o[2], wr[2], rd[2];
  logic [2:0] addr[2];
  logic [15:0] dout[2], din[2];
  logic [255:0] vo[2];
  for (genvar g = 0; g < 2; g++) begin : gd
    vreg_serial_master #(.RD_LAT(g == 0 ? 1 : 3)) u (
      .Clk(clk), .Rst_n(rst_n), .Start(start), .Dir(dir), .VAddr(vaddr), .VecIn(vecin),
      .Busy(busy[g]), .Done(done_o[g]), .VecOut(vo[g]), .Addr(addr[g]),
      .WR_s(wr[g]), .RD_s(rd[g]), .DataOut_s(dout[g]), .DataIn_s(din[g]));
  end
  initial clk = 0;
  always #5 clk = ~clk;
  // regfile model: registered address, element select restarts on each strobe rise
  logic [255:0] rf[2][8];
  logic [2:0] ra[2];
  int sel[2];
  logic pstb[2];
  logic [15:0] pipe[2][3];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int s;
      s = ((wr[i] | rd[i]) && !pstb[i]) ? 0 : sel[i];
      if (wr[i] && s < 16) rf[i][ra[i]][s*16 +: 16] <= dout[i];
      pipe[i][0] <= (rd[i] && s < 16) ? rf[i][ra[i]][s*16 +: 16] : 16'($urandom);
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
      sel[i] <= (wr[i] | rd[i]) ? s + 1 : sel[i];
      pstb[i] <= wr[i] | rd[i];
      ra[i] <= addr[i];
    end
  end
  assign din[0] = pipe[0][0];
  assign din[1] = pipe[1][2];
  int total = 0, bad = 0, cyc = 0, phase = 0;
  int t[2], acc[2];
  logic mdir[2];
  logic [2:0] maddr[2];
  logic [255:0] mvec[2], mout[2], mload[2], shadow[2][8];
  task automatic chk(input string nm, input int inst, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", nm, inst, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int l, dl;
      logic we, re;
      l = i == 0 ? 1 : 3;
      if (!rst_n) begin
        t[i] = 0;
        maddr[i] = '0;
        mout[i] = '0;
        chk("rst_busy", i, busy[i], 0);
        chk("rst_done", i, done_o[i], 0);
        chk("rst_wr", i, wr[i], 0);
        chk("rst_rd", i, rd[i], 0);
        chk("rst_addr", i, addr[i], 0);
        chk("rst_dout", i, dout[i], 0);
        chk("rst_vecout", i, vo[i], 0);
      end else begin
        dl = mdir[i] ? 18 + l : 18;
        if (t[i] == dl && mdir[i]) mout[i] = mload[i];
        we = t[i] >= 2 && t[i] <= 17 && !mdir[i];
        re = t[i] >= 2 && t[i] <= 17 && mdir[i];
        chk("busy", i, busy[i], t[i] != 0);
        chk("done", i, done_o[i], t[i] == dl && t[i] != 0);
        chk("wr_s", i, wr[i], we);
        chk("rd_s", i, rd[i], re);
        chk("addr", i, addr[i], maddr[i]);
        chk("vecout", i, vo[i], mout[i]);
        if (we) chk("dout", i, dout[i], mvec[i][(t[i]-2)*16 +: 16]);
        if (done_o[i] && phase == 2) chk("store_lat", i, cyc - acc[i], 18);
        if (done_o[i] && phase == 3) begin
          chk("load_lat", i, cyc - acc[i], i == 0 ? 19 : 21);
          chk("vec_lo", i, vo[i][15:0], 16'hA000);
          chk("vec_hi", i, vo[i][255:240], 16'hA00F);
        end
        if (t[i] != 0 && t[i] == dl) begin
          if (!mdir[i]) begin
            chk("rf_store", i, rf[i][maddr[i]], mvec[i]);
            shadow[i][maddr[i]] = mvec[i];
          end
          t[i] = 0;
        end else if (t[i] != 0) t[i]++;
        else if (start) begin
          t[i] = 1;
          mdir[i] = dir;
          maddr[i] = vaddr;
          mvec[i] = vecin;
          mload[i] = shadow[i][vaddr];
          acc[i] = cyc;
        end
      end
    end
    cyc++;
  end
  function automatic logic [255:0] r256();
    for (int j = 0; j < 8; j++) r256[j*32 +: 32] = $urandom;
  endfunction
  task automatic issue(input logic d, input logic [2:0] a, input logic [255:0] v);
    start = 1;
    dir = d;
    vaddr = a;
    vecin = v;
    @(posedge clk);
    #1 start = 0;
    dir = 1'($urandom);
    vaddr = 3'($urandom);
    vecin = r256();
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 60 && (t[0] != 0 || t[1] != 0); n++) @(posedge clk);
    #1;
  endtask
  initial begin
    logic [255:0] av;
    for (int k = 0; k < 16; k++) av[k*16 +: 16] = 16'hA000 + 16'(k);
    rst_n = 0;
    start = 0;
    dir = 0;
    vaddr = 0;
    vecin = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    for (int a = 0; a < 8; a++) begin
      issue(0, 3'(a), r256());
      wait_idle();
    end
    phase = 2;
    issue(0, 2, av);
    wait_idle();
    phase = 3;
    issue(1, 2, r256());
    wait_idle();
    phase = 5;
    issue(0, 2, r256());
    repeat (4) @(posedge clk);
    #1 start = 1;
    dir = 1;
    vaddr = 7;
    @(posedge clk);
    #1 start = 0;
    repeat (12) @(posedge clk);
    #1 start = 1;
    dir = 1;
    vaddr = 7;
    @(posedge clk);
    #1 start = 0;
    wait_idle();
    phase = 4;
    issue(0, 5, r256());
    repeat (18) @(posedge clk);
    #1 issue(1, 5, r256());
    wait_idle();
    phase = 1;
    issue(1, 2, r256());
    repeat (5) @(posedge clk);
    #3 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    wait_idle();
    issue(1, 2, r256());
    wait_idle();
    phase = 6;
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 issue(1'($urandom), 3'($urandom), r256());
      wait_idle();
    end
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
